// File: rtl/key_cond_pkg.sv
// Shared types and defaults for the push-button conditioner.
package key_cond_pkg;

   typedef enum logic [1:0] {
      RELEASED = 2'd0,
      PRESSED  = 2'd1,
      LONG     = 2'd2
   } key_state_t;

   localparam int unsigned DEBOUNCE_CYCLES_DEF = 500000;
   localparam int unsigned LONG_CYCLES_DEF     = 50000000;

   // Bits needed to hold any value in 0..max_val (never less than one bit).
   function automatic int unsigned cnt_width(input int unsigned max_val);
      return (max_val < 2) ? 1 : $clog2(max_val + 1);
   endfunction

   localparam int unsigned DEB_W_DEF  = cnt_width(DEBOUNCE_CYCLES_DEF);
   localparam int unsigned HOLD_W_DEF = cnt_width(LONG_CYCLES_DEF - 1);

endpackage

// File: rtl/key_debounce_ch.sv
// One key channel: 2-flop synchronizer, debounce filter and press/release/long FSM.
//
//  state    | meaning
//  ---------+-----------------------------------------------------------
//  RELEASED | debounced key is up
//  PRESSED  | debounced key is down, hold counter running
//  LONG     | long press already reported, hold counter frozen until release
module key_debounce_ch
   import key_cond_pkg::*;
#(
   parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
   parameter int unsigned LONG_CYCLES     = LONG_CYCLES_DEF
) (
   input  logic clk_clk,
   input  logic reset_reset,
   input  logic key_n_raw,
   output logic key_level,
   output logic press_pulse,
   output logic release_pulse,
   output logic long_pulse,
   output logic key_held
);

   localparam int unsigned DEB_W  = cnt_width(DEBOUNCE_CYCLES);
   localparam int unsigned HOLD_W = cnt_width(LONG_CYCLES - 1);
   localparam logic [DEB_W-1:0]  DEB_LAST  = DEB_W'(DEBOUNCE_CYCLES - 1);
   localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(LONG_CYCLES - 1);

   logic              sync1_q;
   logic              sync2_q;
   logic              stable_q;
   logic [DEB_W-1:0]  deb_cnt_q;

   key_state_t        state_q;
   key_state_t        state_d;
   logic [HOLD_W-1:0] hold_q;
   logic [HOLD_W-1:0] hold_d;
   logic              press_d;
   logic              release_d;
   logic              long_d;

   always_ff @(posedge clk_clk) begin
      if (reset_reset) begin
         sync1_q   <= 1'b1;
         sync2_q   <= 1'b1;
         stable_q  <= 1'b1;
         deb_cnt_q <= '0;
      end else begin
         sync1_q <= key_n_raw;
         sync2_q <= sync1_q;
         if (sync2_q == stable_q) begin
            deb_cnt_q <= '0;
         end else if (deb_cnt_q == DEB_LAST) begin
            stable_q  <= sync2_q;
            deb_cnt_q <= '0;
         end else begin
            deb_cnt_q <= deb_cnt_q + 1'b1;
         end
      end
   end

   // Release is checked before the long-press terminal count, so a release
   // landing on that same cycle suppresses long_pulse.
   always_comb begin
      state_d   = state_q;
      hold_d    = hold_q;
      press_d   = 1'b0;
      release_d = 1'b0;
      long_d    = 1'b0;
      case (state_q)
         RELEASED: begin
            if (!stable_q) begin
               state_d = PRESSED;
               hold_d  = '0;
               press_d = 1'b1;
            end
         end
         PRESSED: begin
            if (stable_q) begin
               state_d   = RELEASED;
               release_d = 1'b1;
            end else if (hold_q == HOLD_LAST) begin
               state_d = LONG;
               long_d  = 1'b1;
            end else begin
               hold_d = hold_q + 1'b1;
            end
         end
         LONG: begin
            if (stable_q) begin
               state_d   = RELEASED;
               release_d = 1'b1;
            end
         end
         default: state_d = RELEASED;
      endcase
   end

   always_ff @(posedge clk_clk) begin
      if (reset_reset) begin
         state_q       <= RELEASED;
         hold_q        <= '0;
         press_pulse   <= 1'b0;
         release_pulse <= 1'b0;
         long_pulse    <= 1'b0;
         key_held      <= 1'b0;
         key_level     <= 1'b1;
      end else begin
         state_q       <= state_d;
         hold_q        <= hold_d;
         press_pulse   <= press_d;
         release_pulse <= release_d;
         long_pulse    <= long_d;
         key_held      <= (state_d != RELEASED);
         key_level     <= (state_d == RELEASED);
      end
   end

endmodule

// File: rtl/key_conditioner.sv
// Push-button conditioner feeding the key PIO: NUM_KEYS independent channels.
module key_conditioner
   import key_cond_pkg::*;
#(
   parameter int unsigned NUM_KEYS        = 2,
   parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
   parameter int unsigned LONG_CYCLES     = LONG_CYCLES_DEF
) (
   input  logic                clk_clk,
   input  logic                reset_reset,
   input  logic [NUM_KEYS-1:0] key_n_raw,
   output logic [NUM_KEYS-1:0] key_level_export,
   output logic [NUM_KEYS-1:0] press_pulse,
   output logic [NUM_KEYS-1:0] release_pulse,
   output logic [NUM_KEYS-1:0] long_pulse,
   output logic [NUM_KEYS-1:0] key_held
);

   for (genvar i = 0; i < NUM_KEYS; i++) begin : g_ch
      key_debounce_ch #(
         .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
         .LONG_CYCLES     (LONG_CYCLES)
      ) u_ch (
         .clk_clk       (clk_clk),
         .reset_reset   (reset_reset),
         .key_n_raw     (key_n_raw[i]),
         .key_level     (key_level_export[i]),
         .press_pulse   (press_pulse[i]),
         .release_pulse (release_pulse[i]),
         .long_pulse    (long_pulse[i]),
         .key_held      (key_held[i])
      );
   end

endmodule
